// File: rtl/softmax_result_buffer_16_pkg.sv
// rtl/softmax_result_buffer_16_pkg.sv - shared types and constants for the softmax result buffer
package softmax_result_buffer_16_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int FRAC_BITS = 15;
  localparam int ONE       = 1 << FRAC_BITS;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/softmax_frame_ram_16.sv
// rtl/softmax_frame_ram_16.sv - frame register array, one sync write port, one async read port
module softmax_frame_ram_16 #(
  parameter int data_w = 16,
  parameter int depth  = 10,
  parameter int addr_w = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [addr_w-1:0] waddr_i,
  input  logic [data_w-1:0] wdata_i,
  input  logic [addr_w-1:0] raddr_i,
  output logic [data_w-1:0] rdata_o
);

  logic [data_w-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_result_buffer_16.sv
// rtl/softmax_result_buffer_16.sv - frame buffer with arg-max tracking and valid/ready drain
// Optional sum check on sum_err_o when SOFTMAX_SUM_CHECK_EN is defined.
module softmax_result_buffer_16
  import softmax_result_buffer_16_pkg::*;
#(
  parameter int data_size      = 16,
  parameter int number_of_data = 10,
  parameter int frac_bits      = FRAC_BITS,
  parameter int sum_tol        = 64
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic [data_size-1:0]                 result_data_i,
  input  logic                                 result_data_valid_i,
  input  logic                                 result_done_i,
  output logic [data_size-1:0]                 out_data_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 out_last_o,
  output logic [idx_width(number_of_data)-1:0] argmax_o,
  output logic                                 argmax_valid_o,
  output logic                                 overflow_o
`ifdef SOFTMAX_SUM_CHECK_EN
  ,
  output logic                                 sum_err_o
`endif
);

  localparam int idx_w = idx_width(number_of_data);
  localparam int cnt_w = $clog2(number_of_data + 1);
  localparam logic [cnt_w-1:0] n_c = cnt_w'(number_of_data);

  state_e                 state_q, state_d;
  logic [cnt_w-1:0]       count_q, count_d;
  logic [cnt_w-1:0]       rd_ptr_q, rd_ptr_d;
  logic [data_size-1:0]   max_q, max_d;
  logic [idx_w-1:0]       argmax_q, argmax_d;
  logic                   argmax_valid_q, argmax_valid_d;
  logic                   overflow_q, overflow_d;

  logic                   accept;
  logic                   drop;
  logic                   last_word;
  logic                   xfer_last;
  logic                   enter_drain;
  logic [data_size-1:0]   ram_rdata;

  // Writes are only possible while a frame slot is free; everything else is dropped.
  assign accept    = result_data_valid_i &&
                     ((state_q == IDLE) || ((state_q == COLLECT) && (count_q != n_c)));
  assign drop      = result_data_valid_i && !accept;
  assign last_word = (rd_ptr_q == count_q - cnt_w'(1));
  assign xfer_last = (state_q == DRAIN) && out_ready_i && last_word;
  assign enter_drain = (state_d == DRAIN) && (state_q != DRAIN);

  softmax_frame_ram_16 #(
    .data_w (data_size),
    .depth  (number_of_data),
    .addr_w (idx_w)
  ) u_ram (
    .clk_i   (clock_i),
    .we_i    (accept),
    .waddr_i (count_q[idx_w-1:0]),
    .wdata_i (result_data_i),
    .raddr_i (rd_ptr_q[idx_w-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      max_q          <= '0;
      argmax_q       <= '0;
      argmax_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      max_q          <= max_d;
      argmax_q       <= argmax_d;
      argmax_valid_q <= argmax_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (result_data_valid_i) begin
          state_d = (result_done_i || (number_of_data == 1)) ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        if (result_done_i || (accept && (count_q == n_c - cnt_w'(1)))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    max_d          = max_q;
    argmax_d       = argmax_q;
    overflow_d     = overflow_q | drop;
    argmax_valid_d = enter_drain;
    if (accept) begin
      count_d = count_q + cnt_w'(1);
      // Strict compare keeps the lowest index on ties; the first word always loads.
      if ((state_q == IDLE) || (result_data_i > max_q)) begin
        max_d    = result_data_i;
        argmax_d = count_q[idx_w-1:0];
      end
    end
    if ((state_q == DRAIN) && out_ready_i) begin
      rd_ptr_d = rd_ptr_q + cnt_w'(1);
    end
    if (xfer_last) begin
      count_d  = '0;
      rd_ptr_d = '0;
      max_d    = '0;
    end
  end

  always_comb begin
    out_valid_o    = (state_q == DRAIN);
    out_data_o     = out_valid_o ? ram_rdata : '0;
    out_last_o     = out_valid_o && last_word;
    argmax_o       = argmax_q;
    argmax_valid_o = argmax_valid_q;
    overflow_o     = overflow_q;
  end

`ifdef SOFTMAX_SUM_CHECK_EN
  localparam int acc_w = data_size + $clog2(number_of_data);
  localparam logic [acc_w-1:0] one_c = acc_w'(ONE);
  localparam logic [acc_w-1:0] tol_c = acc_w'(sum_tol);

  logic [acc_w-1:0] acc_q, acc_d;
  logic             sum_err_q, sum_err_d;
  logic [acc_w-1:0] sum_diff;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sum_err_q <= sum_err_d;
    end
  end

  // acc_d already includes a word written on the same cycle as the done pulse.
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = ((state_q == IDLE) ? '0 : acc_q) + acc_w'(result_data_i);
    end
    if (xfer_last) begin
      acc_d = '0;
    end
    sum_diff  = (acc_d >= one_c) ? (acc_d - one_c) : (one_c - acc_d);
    sum_err_d = enter_drain ? (sum_diff > tol_c) : sum_err_q;
  end

  assign sum_err_o = sum_err_q;
`endif

endmodule

// File: tb/tb_softmax_result_buffer_16.sv
// tb/tb_softmax_result_buffer_16.sv - scoreboard bench for softmax_result_buffer_16
module tb_softmax_result_buffer_16;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [15:0] result_data_i;
  logic        result_data_valid_i;
  logic        result_done_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;
  logic [3:0]  argmax_o;
  logic        argmax_valid_o;
  logic        overflow_o;
`ifdef SOFTMAX_SUM_CHECK_EN
  logic        sum_err_o;
`endif

  softmax_result_buffer_16 dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .result_data_i       (result_data_i),
    .result_data_valid_i (result_data_valid_i),
    .result_done_i       (result_done_i),
    .out_data_o          (out_data_o),
    .out_valid_o         (out_valid_o),
    .out_ready_i         (out_ready_i),
    .out_last_o          (out_last_o),
    .argmax_o            (argmax_o),
    .argmax_valid_o      (argmax_valid_o),
    .overflow_o          (overflow_o)
`ifdef SOFTMAX_SUM_CHECK_EN
    ,
    .sum_err_o           (sum_err_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  int          errors = 0;
  int          checks = 0;
  int          vcyc = 0;
  int          xfers = 0;
  bit          bp_mode = 1'b0;
  exp_t        exp_q[$];
  int          arg_q[$];
  logic [15:0] fw[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Ready driver: always ready, or low on the first drain cycle and then alternating.
  initial begin
    bit phase;
    phase = 1'b0;
    out_ready_i = 1'b1;
    forever begin
      @(posedge clock_i);
      #1;
      if (bp_mode) begin
        out_ready_i = out_valid_o && phase;
        phase = out_valid_o ? ~phase : 1'b0;
      end else begin
        out_ready_i = 1'b1;
        phase = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clock_i);
      if (!reset_i && out_valid_o) begin
        vcyc++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'h0, out_data_o}, 32'hDEAD_BEEF);
        end else if (out_ready_i) begin
          e = exp_q.pop_front();
          check("drain_data", {16'h0, out_data_o}, {16'h0, e.d});
          check("drain_last", {31'h0, out_last_o}, {31'h0, e.l});
          xfers++;
        end else begin
          check("stall_data", {16'h0, out_data_o}, {16'h0, exp_q[0].d});
          check("stall_last", {31'h0, out_last_o}, {31'h0, exp_q[0].l});
        end
      end
      if (argmax_valid_o) begin
        if (arg_q.size() == 0) begin
          check("unexpected_argmax_pulse", {31'h0, argmax_valid_o}, 32'h0);
        end else begin
          a = arg_q.pop_front();
          check("argmax", {28'h0, argmax_o}, a);
          check("argmax_with_valid", {31'h0, out_valid_o}, 32'h1);
        end
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clock_i);
    #1;
    result_data_valid_i = 1'b0;
    result_done_i       = 1'b0;
  endtask

  // Sends fw[]; done either with the last word or as a separate pulse.
  task automatic send_frame(input int exp_arg, input bit done_sep);
    arg_q.push_back(exp_arg);
    vcyc = 0;
    for (int i = 0; i < fw.size(); i++) begin
      exp_t e;
      e.d = fw[i];
      e.l = (i == fw.size() - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < fw.size(); i++) begin
      @(posedge clock_i);
      #1;
      result_data_valid_i = 1'b1;
      result_data_i       = fw[i];
      result_done_i       = !done_sep && (i == fw.size() - 1);
    end
    @(posedge clock_i);
    #1;
    result_data_valid_i = 1'b0;
    result_done_i       = done_sep;
    if (done_sep) idle_cycle();
  endtask

  task automatic drain_wait(input string name, input int exp_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock_i);
      #1;
      if (vcyc > 0 && !out_valid_o) done = 1'b1;
    end
    check({name, "_drain_done"}, {31'h0, done}, 32'h1);
    check({name, "_drain_cycles"}, vcyc, exp_cycles);
    check({name, "_queue_empty"}, exp_q.size() + arg_q.size(), 0);
  endtask

  initial begin
    reset_i             = 1'b1;
    result_data_i       = '0;
    result_data_valid_i = 1'b0;
    result_done_i       = 1'b0;
    repeat (3) @(posedge clock_i);
    #2;
    check("rst_valid", {31'h0, out_valid_o}, 0);
    check("rst_data", {16'h0, out_data_o}, 0);
    check("rst_last", {31'h0, out_last_o}, 0);
    check("rst_argmax", {28'h0, argmax_o}, 0);
    check("rst_argmax_valid", {31'h0, argmax_valid_o}, 0);
    check("rst_overflow", {31'h0, overflow_o}, 0);
`ifdef SOFTMAX_SUM_CHECK_EN
    check("rst_sum_err", {31'h0, sum_err_o}, 0);
`endif
    @(negedge clock_i);
    reset_i = 1'b0;

    // done with no word in IDLE is ignored
    @(posedge clock_i);
    #1;
    result_done_i = 1'b1;
    idle_cycle();
    repeat (2) @(posedge clock_i);
    #2;
    check("idle_done_ignored", {31'h0, out_valid_o}, 0);

    fw = '{16'h0100, 16'h0200, 16'h0800, 16'h7000, 16'h0300,
           16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0050};
    send_frame(3, 1'b0);
    drain_wait("basic", 10);

    fw = '{16'h1000, 16'h2000, 16'h4000, 16'h0100, 16'h3000,
           16'h0200, 16'h0300, 16'h4000, 16'h0010, 16'h0020};
    send_frame(2, 1'b0);
    drain_wait("tie", 10);

    bp_mode = 1'b1;
    fw = '{16'h0100, 16'h0200, 16'h0800, 16'h7000, 16'h0300,
           16'h0400, 16'h0500, 16'h0600, 16'h0700, 16'h0050};
    send_frame(3, 1'b0);
    drain_wait("backpressure", 20);
    bp_mode = 1'b0;

    fw = '{16'h0010, 16'h0500, 16'h0400, 16'h0020};
    send_frame(1, 1'b1);
    drain_wait("short", 4);
    check("no_overflow_yet", {31'h0, overflow_o}, 0);

    fw = '{16'h0A00, 16'h0B00, 16'h0C00, 16'h0900, 16'h0800,
           16'h0700, 16'h0600, 16'h0500, 16'h0400, 16'h0300};
    send_frame(2, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clock_i);
        #1;
        if (out_valid_o) seen = 1'b1;
      end
      check("ovf_drain_started", {31'h0, seen}, 1);
    end
    @(posedge clock_i);
    #1;
    result_data_valid_i = 1'b1;
    result_data_i       = 16'hFFFF;
    @(posedge clock_i);
    #1;
    result_data_i       = 16'hFFFE;
    idle_cycle();
    drain_wait("overflow", 10);
    check("overflow_set", {31'h0, overflow_o}, 1);

    fw = '{16'h0100, 16'h0900, 16'h0200, 16'h0300, 16'h0400};
    xfers = 0;
    send_frame(1, 1'b1);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(negedge clock_i);
        #1;
        if (xfers >= 3) hit = 1'b1;
      end
      check("rst_mid_three_xfers", {31'h0, hit}, 1);
    end
    reset_i = 1'b1;
    #1;
    check("rstmid_valid", {31'h0, out_valid_o}, 0);
    check("rstmid_data", {16'h0, out_data_o}, 0);
    check("rstmid_last", {31'h0, out_last_o}, 0);
    check("rstmid_argmax", {28'h0, argmax_o}, 0);
    check("rstmid_overflow", {31'h0, overflow_o}, 0);
    exp_q.delete();
    arg_q.delete();
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #2;
    check("post_rst_no_drain", {31'h0, out_valid_o}, 0);
    fw = '{16'h0A00, 16'h0B00, 16'h0C00};
    send_frame(2, 1'b1);
    drain_wait("after_reset", 3);

`ifdef SOFTMAX_SUM_CHECK_EN
    fw = '{16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD,
           16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD, 16'h0CCD};
    send_frame(0, 1'b0);
    drain_wait("sum_ok", 10);
    check("sum_err_ok", {31'h0, sum_err_o}, 0);

    fw = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
    send_frame(0, 1'b1);
    drain_wait("sum_low", 7);
    check("sum_err_low", {31'h0, sum_err_o}, 1);
`endif

    repeat (3) @(posedge clock_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/softmax_result_buffer_16.md
# softmax_result_buffer_16

Collects the 16-bit probability stream from the softmax pipeline's final exp stage into a local frame buffer and tracks the arg-max element while it arrives. On frame completion it reports the arg-max index and drains the frame over a valid/ready stream. This gives the non-stallable softmax pipeline a backpressure-capable consumer port.

## Interface
- data_size, 16: width of each probability word (unsigned, `frac_bits` fractional bits)
- number_of_data, 10: frame length N; buffer depth
- frac_bits, 15: fractional bits of the probability format
- sum_tol, 64: allowed |sum − 1.0| in LSBs (sum check only)
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- result_data_i  in  data_size  probability word from the exp stage
- result_data_valid_i  in  1  result_data_i valid this cycle; no ready back to the source
- result_done_i  in  1  one-cycle end-of-frame pulse from the exp stage
- out_data_o  out  data_size  buffered word at the read pointer
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  sink accepts a word
- out_last_o  out  1  last word of the frame
- argmax_o  out  $clog2(number_of_data)  index of the largest word in the frame
- argmax_valid_o  out  1  one-cycle pulse; argmax_o is valid
- overflow_o  out  1  sticky; an input word was dropped

## Operation
- FSM states: IDLE, COLLECT, DRAIN. On reset, or while reset_i is high: IDLE, all outputs 0, pointers, count and max cleared. Buffer contents are don't-care.
- IDLE:
  - A valid word writes buf[0], loads max = word and argmax = 0, sets count = 1, and moves to COLLECT.
  - result_done_i with no valid word is ignored.
- COLLECT:
  - Each valid word writes buf[count] and increments count.
  - If word > max (strict), max and argmax are updated. Ties keep the lowest index.
  - The FSM moves to DRAIN on the cycle after the write that makes count == N, or on the cycle after result_done_i.
  - result_done_i together with a valid word: the word is written first, then one transition to DRAIN.
  - A short frame (done before N words) drains `count` words.
- DRAIN:
  - out_valid_o = 1 and out_data_o = buf[rd_ptr], starting from rd_ptr = 0.
  - A transfer happens when out_valid_o && out_ready_i; each transfer increments rd_ptr.
  - out_last_o = (rd_ptr == count − 1).
  - After the last transfer the FSM returns to IDLE and clears count, rd_ptr and max.
- Input words arriving in DRAIN (or in COLLECT once count == N) are dropped and set overflow_o. overflow_o clears only on reset.
- Comparison is unsigned, full data_size width.

## Timing
- Write latency: one cycle from input valid to the buffer.
- argmax_valid_o pulses in the first DRAIN cycle, together with the first out_valid_o.
- out_data_o is combinational from the buffer register at rd_ptr, so the first word is available on the first DRAIN cycle.
- If out_ready_i is held high, the drain takes exactly `count` cycles, with one IDLE cycle after it.
- out_valid_o stays high while stalled. out_data_o and out_last_o must remain stable until the transfer occurs.
- Reset mid-frame or mid-drain: immediate abort. No argmax pulse and no partial drain after release.

## Configuration
- SOFTMAX_SUM_CHECK_EN defined:
  - Adds a sum_err_o output (1 bit) and an accumulator of width data_size + $clog2(number_of_data).
  - The accumulator clears with the frame and adds every word written.
  - On entering DRAIN, sum_err_o is registered as |sum − (1 << frac_bits)| > sum_tol and held until the next frame enters DRAIN or until reset.
- SOFTMAX_SUM_CHECK_EN not defined: no port, no accumulator; all other behaviour is identical.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE/COLLECT/DRAIN);
  - a function for the index width, $clog2(number_of_data) with a minimum of 1;
  - the constant ONE = 1 << frac_bits, reused by the sum check.
- One sub-module, softmax_frame_ram_16: a register array with one synchronous write port and one asynchronous read port. The FSM, the arg-max tracker and the sum check stay in the top module.

## Test plan
- 10 words 0x0100, 0x0200, 0x0800, 0x7000, 0x0300, …, with result_done_i on the 10th word and out_ready_i = 1:
  - argmax_o = 3 pulsed once;
  - 10 words drained in order;
  - out_last_o on word 10; back to IDLE.
- Tie: words 0x4000 at index 2 and index 7 → argmax_o = 2.
- Backpressure: out_ready_i toggles every other cycle → each word held stable while stalled, no loss or duplication, drain takes 20 cycles.
- Short frame: 4 valid words, then result_done_i → 4 words drained, out_last_o on the 4th word, argmax correct.
- Overflow: 2 valid words during DRAIN → words dropped, overflow_o = 1, drained frame unchanged.
- Reset mid-drain: reset_i asserted after the 3rd transfer → all outputs 0 immediately; the next frame drains from index 0.
- With SOFTMAX_SUM_CHECK_EN: 10 × 0x0CCD (sum 0x8002, within tolerance) → sum_err_o = 0; a frame summing to 0x7000 → sum_err_o = 1.
